row_fifo: RTL and testbench



---
 rtl/row_fifo_if.sv | 32 +++
 rtl/row_fifo.sv | 78 +++++++
 tb/tb_row_fifo.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/row_fifo_if.sv
// Valid/ready word channel used by row_fifo on both its write and read sides.
// The master modport belongs to the surrounding logic.
// That logic produces words and consumes them.
// The slave modport belongs to the FIFO itself.
interface row_fifo_if #(
    parameter int WIDTH = 11
);
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output wr_valid,
        output wr_data,
        input  wr_ready,
        input  rd_valid,
        input  rd_data,
        output rd_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        output wr_ready,
        output rd_valid,
        output rd_data,
        input  rd_ready
    );
endinterface

// File: rtl/row_fifo.sv
// First-word-fall-through FIFO for cell-row words.
// It sits between the game-state store and the next-generation compute stage.
// Storage is a bank of write-enabled registers addressed by wrapping pointers.
// The oldest word is read combinationally, so a pushed word appears one edge later.
module row_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    row_fifo_if.slave                  bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic             push;
    logic             pop;

    // Status and handshake outputs depend only on registers, never on wr_valid/rd_ready
    always_comb begin
        full         = (count == CW'(DEPTH));
        empty        = (count == '0);
        bus.wr_ready = !full;
        bus.rd_valid = !empty;
        bus.rd_data  = empty ? '0 : mem[rp];
        push         = bus.wr_valid && !full;
        pop          = !empty && bus.rd_ready;
    end

    // Storage bank: a word is written at the tail on every accepted push
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!clear && push) begin
            mem[wp] <= bus.wr_data;
        end
    end

    // Pointers, occupancy and sticky overflow; clear overrides any handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + PW'(1);
            end
            if (pop) begin
                rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (bus.wr_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_row_fifo.sv
// Directed testbench for row_fifo with WIDTH = 11 and DEPTH = 4.
// Every expected value below is worked out by hand from the FIFO ordering rules.
module tb_row_fifo;
    localparam int WIDTH = 11;
    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       clear;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       overflow;

    int assertCount;
    int failCount;

    row_fifo_if #(.WIDTH(WIDTH)) bus ();

    row_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .bus      (bus.slave),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    // Free-running clock with a 10-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic wv, input logic [WIDTH-1:0] wd, input logic rr);
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Directed scenario sequence
    initial begin
        assertCount = 0;
        failCount   = 0;
        reset       = 1'b0;
        clear       = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        #1;
        checkOutput("por_count", 32'(count), 32'd0);
        checkOutput("por_empty", 32'(empty), 32'd1);
        checkOutput("por_wr_ready", 32'(bus.wr_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Fill to full
        applyStimulus(1'b1, 11'h00C, 1'b0);
        cycle();
        checkOutput("first_rd_valid", 32'(bus.rd_valid), 32'd1);
        checkOutput("first_rd_data", 32'(bus.rd_data), 32'h00C);
        checkOutput("first_count", 32'(count), 32'd1);
        applyStimulus(1'b1, 11'h3FF, 1'b0);
        cycle();
        applyStimulus(1'b1, 11'h001, 1'b0);
        cycle();
        applyStimulus(1'b1, 11'h555, 1'b0);
        cycle();
        checkOutput("fill_full", 32'(full), 32'd1);
        checkOutput("fill_count", 32'(count), 32'd4);
        checkOutput("fill_wr_ready", 32'(bus.wr_ready), 32'd0);
        checkOutput("fill_rd_data", 32'(bus.rd_data), 32'h00C);

        // Two writes while full are dropped and set overflow
        applyStimulus(1'b1, 11'h7AA, 1'b0);
        cycle();
        cycle();
        checkOutput("ovf_flag", 32'(overflow), 32'd1);
        checkOutput("ovf_count", 32'(count), 32'd4);

        // Drain in order
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("drain0", 32'(bus.rd_data), 32'h00C);
        cycle();
        checkOutput("drain1", 32'(bus.rd_data), 32'h3FF);
        cycle();
        checkOutput("drain2", 32'(bus.rd_data), 32'h001);
        cycle();
        checkOutput("drain3", 32'(bus.rd_data), 32'h555);
        cycle();
        checkOutput("drain_empty", 32'(empty), 32'd1);
        checkOutput("drain_rd_valid", 32'(bus.rd_valid), 32'd0);
        checkOutput("drain_rd_data", 32'(bus.rd_data), 32'h000);
        checkOutput("drain_count", 32'(count), 32'd0);
        checkOutput("ovf_sticky", 32'(overflow), 32'd1);

        // Clear drops the sticky overflow
        applyStimulus(1'b0, '0, 1'b0);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        checkOutput("clear_ovf", 32'(overflow), 32'd0);

        // Wrap-around with two words resident
        applyStimulus(1'b1, 11'd0, 1'b0);
        cycle();
        applyStimulus(1'b1, 11'd1, 1'b0);
        cycle();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 11'(i + 2), 1'b1);
            checkOutput($sformatf("wrap_data%0d", i), 32'(bus.rd_data), 32'(i));
            cycle();
            checkOutput($sformatf("wrap_count%0d", i), 32'(count), 32'd2);
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("wrap_tail0", 32'(bus.rd_data), 32'd10);
        cycle();
        checkOutput("wrap_tail1", 32'(bus.rd_data), 32'd11);
        cycle();
        checkOutput("wrap_empty", 32'(empty), 32'd1);

        // Backpressure: head holds while the consumer stalls
        applyStimulus(1'b1, 11'h100, 1'b0);
        cycle();
        applyStimulus(1'b1, 11'h101, 1'b0);
        cycle();
        applyStimulus(1'b1, 11'h102, 1'b0);
        cycle();
        checkOutput("bp_head", 32'(bus.rd_data), 32'h100);
        checkOutput("bp_count", 32'(count), 32'd3);
        applyStimulus(1'b1, 11'h103, 1'b1);
        checkOutput("bp_pp0_data", 32'(bus.rd_data), 32'h100);
        cycle();
        checkOutput("bp_pp0_count", 32'(count), 32'd3);
        applyStimulus(1'b1, 11'h104, 1'b1);
        checkOutput("bp_pp1_data", 32'(bus.rd_data), 32'h101);
        cycle();
        checkOutput("bp_pp1_count", 32'(count), 32'd3);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("bp_d0", 32'(bus.rd_data), 32'h102);
        cycle();
        checkOutput("bp_d1", 32'(bus.rd_data), 32'h103);
        cycle();
        checkOutput("bp_d2", 32'(bus.rd_data), 32'h104);
        cycle();
        checkOutput("bp_empty", 32'(empty), 32'd1);

        // Clear wins over a simultaneous push and pop
        applyStimulus(1'b1, 11'h0AA, 1'b0);
        cycle();
        applyStimulus(1'b1, 11'h0BB, 1'b0);
        cycle();
        checkOutput("pre_clear_count", 32'(count), 32'd2);
        applyStimulus(1'b1, 11'h0CC, 1'b1);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("clr_count", 32'(count), 32'd0);
        checkOutput("clr_empty", 32'(empty), 32'd1);
        checkOutput("clr_rd_data", 32'(bus.rd_data), 32'h000);
        applyStimulus(1'b1, 11'h011, 1'b0);
        cycle();
        checkOutput("post_clr_data", 32'(bus.rd_data), 32'h011);
        checkOutput("post_clr_count", 32'(count), 32'd1);

        // Build a half-full FIFO with overflow set, then reset asynchronously
        applyStimulus(1'b1, 11'h012, 1'b0);
        cycle();
        applyStimulus(1'b1, 11'h013, 1'b0);
        cycle();
        applyStimulus(1'b1, 11'h014, 1'b0);
        cycle();
        applyStimulus(1'b1, 11'h7AA, 1'b0);
        cycle();
        applyStimulus(1'b0, '0, 1'b1);
        cycle();
        cycle();
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("half_count", 32'(count), 32'd2);
        checkOutput("half_head", 32'(bus.rd_data), 32'h013);
        checkOutput("half_ovf", 32'(overflow), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        checkOutput("rst_rd_data", 32'(bus.rd_data), 32'h000);
        checkOutput("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        checkOutput("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b1, 11'h077, 1'b0);
        cycle();
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("after_rst_data", 32'(bus.rd_data), 32'h077);
        checkOutput("after_rst_count", 32'(count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
